interrupt_sequencer: RTL

Arbitrates the 6502 core's interrupt sources (reset, NMI, IRQ, software BRK) and schedules the shared BRK microsequence run by the PLA state machine. It decides at each opcode-fetch slot whether the sequence is hijacked by an interrupt. It selects the vector and B-flag value for that sequence, and tracks the sequence until the state machine reports completion. It sits between the external interrupt pins and the control FSM, driving that FSM's `brkNow` input and consuming its `intHandled` output.

---
 rtl/interrupt_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt arbiter for the 6502 core: picks reset/NMI/IRQ/BRK, drives brkNow and tracks the shared BRK sequence.
// Optional macro INT_SYNC_EN adds 2-flop synchronizers on nmi_n and irq_n.
module interrupt_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       phi1,
  input  logic       rst,
  input  logic       haltAll,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       iFlag,
  input  logic       fsmFetch,
  input  logic       brkOpcode,
  input  logic       intHandled,
  output logic       brkNow,
  output logic [1:0] vecSel,
  output logic       setB,
  output logic       nmiPend,
  output logic       timeoutErr
);

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    IDLE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       nmiPrev;
  logic       nmi_pin;
  logic       irq_pin;
  logic       irq_req;
  logic       nmi_edge;
  logic       nmi_take;

`ifdef INT_SYNC_EN
  logic [1:0] nmi_sync;
  logic [1:0] irq_sync;

  always_ff @(posedge phi1) begin
    if (rst) begin
      nmi_sync <= 2'b11;
      irq_sync <= 2'b11;
    end else if (!haltAll) begin
      nmi_sync <= {nmi_sync[0], nmi_n};
      irq_sync <= {irq_sync[0], irq_n};
    end
  end

  assign nmi_pin = nmi_sync[1];
  assign irq_pin = irq_sync[1];
`else
  assign nmi_pin = nmi_n;
  assign irq_pin = irq_n;
`endif

  assign irq_req  = ~irq_pin & ~iFlag;
  assign nmi_edge = nmiPrev & ~nmi_pin;
  assign brkNow   = ~haltAll & fsmFetch & (state == IDLE) & (nmiPend | irq_req | brkOpcode);
  assign nmi_take = brkNow & nmiPend;

  always_ff @(posedge phi1) begin
    if (rst) begin
      state      <= RST_SEQ;
      vecSel     <= 2'b10;
      setB       <= 1'b0;
      nmiPend    <= 1'b0;
      nmiPrev    <= 1'b1;
      timeoutErr <= 1'b0;
      cnt        <= 4'd0;
    end else if (!haltAll) begin
      nmiPrev <= nmi_pin;
      // A new edge beats the clear from a simultaneous NMI hijack.
      nmiPend <= nmi_edge | (nmiPend & ~nmi_take);
      case (state)
        IDLE: begin
          if (brkNow) begin
            state <= SERVICE;
            cnt   <= 4'd0;
            if (nmiPend) begin
              vecSel <= 2'b01;
              setB   <= 1'b0;
            end else if (irq_req) begin
              vecSel <= 2'b00;
              setB   <= 1'b0;
            end else begin
              vecSel <= 2'b00;
              setB   <= 1'b1;
            end
          end
        end
        default: begin
          // intHandled has priority over the watchdog expiring on the same cycle.
          if (intHandled) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            timeoutErr <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
